// File: rtl/tt_checker_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } tt_state_e;

  // Width needed to count every mismatched bit of a full sweep without wrapping.
  function automatic int tt_cnt_w(input int in_w, input int out_n);
    return $clog2(out_n * (2 ** in_w) + 1);
  endfunction

endpackage

// File: rtl/tt_popcount.sv
// Combinational population count of an N-bit mismatch vector.
module tt_popcount #(
  parameter int N = 3,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits_i,
  output logic [W-1:0] count_o
);

  // Sum of set bits.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep checker with settle/hold timing and sticky error stats.
// Optional build macro: TT_STOP_ON_ERR_EN (stop the sweep at the first mismatching vector).
module tt_sweep_checker
  import tt_checker_pkg::*;
#(
  parameter int                         IN_W   = 3,
  parameter int                         OUT_N  = 3,
  parameter logic [OUT_N*(2**IN_W)-1:0] TT     = {8'b01011100, 8'b10110010, 8'b00111001},
  parameter int                         SETTLE = 6,
  parameter int                         HOLD   = 3,
  localparam int                        CNT_W  = tt_cnt_w(IN_W, OUT_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OUT_N-1:0] dut_z,
  output logic [IN_W-1:0]  stim,
  output logic             check_point,
  output logic             busy,
  output logic             done,
  output logic [OUT_N-1:0] err_mask,
  output logic [CNT_W-1:0] err_count,
  output logic [IN_W-1:0]  first_err_stim
);

  localparam int NV   = 2 ** IN_W;
  localparam int CMAX = (SETTLE > HOLD) ? SETTLE : HOLD;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   HOLD_LAST   = CW'((HOLD > 0) ? (HOLD - 1) : 0);
  localparam logic [IN_W-1:0] STIM_LAST   = {IN_W{1'b1}};

`ifdef TT_STOP_ON_ERR_EN
  localparam logic STOP_ON_ERR = 1'b1;
`else
  localparam logic STOP_ON_ERR = 1'b0;
`endif

  tt_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic             check_point_q, check_point_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [OUT_N-1:0] err_mask_q, err_mask_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [IN_W-1:0]  first_err_q, first_err_d;

  logic [OUT_N-1:0] exp_s;
  logic [OUT_N-1:0] mism_s;
  logic [CNT_W-1:0] pop_s;
  logic             step_s;

  // Expected output bits for the vector currently applied.
  always_comb begin
    exp_s = '0;
    for (int k = 0; k < OUT_N; k++) begin
      exp_s[k] = TT[k * NV + int'(stim_q)];
    end
  end

  assign mism_s = dut_z ^ exp_s;

  tt_popcount #(
    .N (OUT_N),
    .W (CNT_W)
  ) u_popcount (
    .bits_i  (mism_s),
    .count_o (pop_s)
  );

  // Sweep sequencing, error accumulation and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stim_d      = stim_q;
    err_mask_d  = err_mask_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    step_s      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_APPLY;
          cnt_d       = '0;
          stim_d      = '0;
          err_mask_d  = '0;
          err_count_d = '0;
          first_err_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_APPLY: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CHECK: begin
        err_mask_d  = err_mask_q | mism_s;
        err_count_d = err_count_q + pop_s;
        if ((err_mask_q == '0) && (mism_s != '0)) begin
          first_err_d = stim_q;
        end else begin
          first_err_d = first_err_q;
        end
        if (STOP_ON_ERR && (mism_s != '0)) begin
          state_d = ST_DONE;
        end else if (HOLD == 0) begin
          step_s = 1'b1;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          step_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Advance to the next vector, or finish after the last one.
    if (step_s) begin
      cnt_d = '0;
      if (stim_q == STIM_LAST) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_APPLY;
        stim_d  = stim_q + IN_W'(1);
      end
    end else begin
      cnt_d = cnt_d;
    end

    check_point_d = (state_d == ST_CHECK);
    busy_d        = (state_d == ST_APPLY) || (state_d == ST_CHECK) || (state_d == ST_HOLD);
    done_d        = (state_d == ST_DONE);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      stim_q        <= '0;
      check_point_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_mask_q    <= '0;
      err_count_q   <= '0;
      first_err_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stim_q        <= stim_d;
      check_point_q <= check_point_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_mask_q    <= err_mask_d;
      err_count_q   <= err_count_d;
      first_err_q   <= first_err_d;
    end
  end

  assign stim           = stim_q;
  assign check_point    = check_point_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_mask       = err_mask_q;
  assign err_count      = err_count_q;
  assign first_err_stim = first_err_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: modelled block under test, queued sweep results.
module tb_tt_sweep_checker;

  localparam int CNT_W = tt_checker_pkg::tt_cnt_w(3, 3);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       dut_z;
  logic [2:0]       stim;
  logic             check_point;
  logic             busy;
  logic             done;
  logic [2:0]       err_mask;
  logic [CNT_W-1:0] err_count;
  logic [2:0]       first_err_stim;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mode_r = 0;

  logic [7:0] tt2 = 8'b01011100;
  logic [7:0] tt1 = 8'b10110010;
  logic [7:0] tt0 = 8'b00111001;

  typedef struct {
    logic [2:0]       mask;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       first;
    logic [2:0]       stim;
    int               ncp;
    int               lat;
  } exp_t;

  exp_t sb_q[$];

  tt_sweep_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .dut_z          (dut_z),
    .stim           (stim),
    .check_point    (check_point),
    .busy           (busy),
    .done           (done),
    .err_mask       (err_mask),
    .err_count      (err_count),
    .first_err_stim (first_err_stim)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Block under test: correct, z1 stuck-at-0, all inverted, or z2 inverted at vector 3.
  always_comb begin
    dut_z = {tt2[stim], tt1[stim], tt0[stim]};
    case (mode_r)
      1:       dut_z[1] = 1'b0;
      2:       dut_z = ~dut_z;
      3:       if (stim == 3'd3) dut_z[2] = ~dut_z[2];
      default: dut_z = dut_z;
    endcase
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input int mode);
    exp_t e;
    e.ncp  = 8;
    e.lat  = 80;
    e.stim = 3'd7;
    case (mode)
      0:       begin e.mask = 3'b000; e.cnt = 5'd0;  e.first = 3'd0; end
      1:       begin e.mask = 3'b010; e.cnt = 5'd4;  e.first = 3'd1; end
      2:       begin e.mask = 3'b111; e.cnt = 5'd24; e.first = 3'd0; end
      default: begin e.mask = 3'b100; e.cnt = 5'd1;  e.first = 3'd3; end
    endcase
`ifdef TT_STOP_ON_ERR_EN
    if (mode != 0) begin
      e.stim = e.first;
      e.cnt  = (mode == 2) ? 5'd3 : 5'd1;
      e.ncp  = int'(e.first) + 1;
      e.lat  = 10 * int'(e.first) + 7;
    end
`endif
    return e;
  endfunction

  // Monitor: sweep-start state, check_point order/spacing, and results when done rises.
  int   t_start = 0;
  int   last_cp = 0;
  int   ncp = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ncp       = 0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        t_start = cyc;
        ncp     = 0;
        chk("start_stim", int'(stim), 0);
        chk("start_mask", int'(err_mask), 0);
        chk("start_count", int'(err_count), 0);
      end
      if (check_point) begin
        chk("cp_stim", int'(stim), ncp);
        if (ncp > 0) chk("cp_spacing", cyc - last_cp, 10);
        last_cp = cyc;
        ncp++;
      end
      if (done && !prev_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("err_mask", int'(err_mask), int'(e.mask));
          chk("err_count", int'(err_count), int'(e.cnt));
          chk("first_err_stim", int'(first_err_stim), int'(e.first));
          chk("final_stim", int'(stim), int'(e.stim));
          chk("num_checks", ncp, e.ncp);
          chk("latency", cyc - t_start, e.lat);
        end
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stim"}, int'(stim), 0);
    chk({tag, "_cp"}, int'(check_point), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_mask"}, int'(err_mask), 0);
    chk({tag, "_count"}, int'(err_count), 0);
    chk({tag, "_first"}, int'(first_err_stim), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_sweep(input int mode);
    mode_r = mode;
    sb_q.push_back(mk_exp(mode));
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
  endtask

  initial begin
    exp_t e;
    int   n;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(0);
    run_sweep(1);
    run_sweep(2);
    run_sweep(3);

    // Abort a sweep with an asynchronous reset during vector 5.
    mode_r = 1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (stim != 3'd5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec5", int'(stim), 5);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(0);

    // start held high for the whole sweep, released at the final check.
    mode_r = 3;
    e = mk_exp(3);
    sb_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b1;
    n = 0;
    while (!(check_point && stim == e.stim) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(check_point && stim == e.stim)) chk("held_start_timeout", 0, 1);
    start = 1'b0;
    wait_done();

    // Restart from DONE clears the previous sweep's statistics.
    run_sweep(0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
